// File: rtl/jesd204_tpl_regmap_initiator_pkg.sv
// jesd204_tpl_regmap_initiator_pkg: opcodes, AXI response codes and FSM encoding shared by the initiator
package jesd204_tpl_regmap_initiator_pkg;
  localparam logic [1:0] OP_WRITE    = 2'b00;
  localparam logic [1:0] OP_READ     = 2'b01;
  localparam logic [1:0] OP_POLL     = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP} state_e;
endpackage

// File: rtl/jesd204_tpl_regmap_initiator_if.sv
// jesd204_tpl_regmap_initiator_if: command/response stream plus AXI4-Lite bus of the regmap initiator.
// Modport master is the initiator (consumes commands, drives AXI requests); modport slave is the
// command source and AXI responder side.
interface jesd204_tpl_regmap_initiator_if;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_data, cmd_mask;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_poll_fail, busy;
  logic        m_axi_awvalid, m_axi_awready;
  logic [11:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [11:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_poll_fail, busy,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_poll_fail, busy,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp
  );
endinterface

// File: rtl/jesd204_tpl_regmap_initiator.sv
// jesd204_tpl_regmap_initiator: single-outstanding AXI4-Lite master turning write/read/poll commands into TPL regmap accesses.
// Ports: up_clk, up_rstn (async active-low), bus (master modport: cmd/rsp stream, busy, AXI4-Lite master).
// Macro JESD204_TPL_REGMAP_INITIATOR_POLL_EN enables the masked poll loop; otherwise op 10 is a plain read.
module jesd204_tpl_regmap_initiator
  import jesd204_tpl_regmap_initiator_pkg::*;
#(
  parameter int POLL_LIMIT = 255
) (
  input logic                            up_clk,
  input logic                            up_rstn,
  jesd204_tpl_regmap_initiator_if.master bus
);
  state_e      state_q, state_d;
  logic [11:0] addr_q;
  logic [31:0] data_q, rsp_data_q;
  logic [1:0]  rsp_resp_q;
  logic        awvalid_q, wvalid_q, arvalid_q;
  logic        cmd_hs, is_wr, b_hs, r_hs, retry, fail;
  assign cmd_hs = state_q == S_IDLE && bus.cmd_valid;
  assign is_wr  = bus.cmd_op == OP_WRITE;
  assign b_hs   = state_q == S_WR_RESP && bus.m_axi_bvalid;
  assign r_hs   = state_q == S_RD_RESP && bus.m_axi_rvalid;
`ifdef JESD204_TPL_REGMAP_INITIATOR_POLL_EN
  logic        is_poll_q, poll_fail_q, hit, last, miss;
  logic [31:0] mask_q;
  logic [15:0] cnt_q;
  assign hit   = ((bus.m_axi_rdata ^ data_q) & mask_q) == '0;
  assign last  = {1'b0, cnt_q} + 17'd1 == 17'(POLL_LIMIT);
  // An error response ends the poll as a normal completion so the caller sees the resp code.
  assign miss  = is_poll_q && !hit && bus.m_axi_rresp == RESP_OKAY;
  assign retry = miss && !last;
  assign fail  = miss && last;
  assign bus.rsp_poll_fail = poll_fail_q;
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      is_poll_q   <= 1'b0;
      mask_q      <= '0;
      cnt_q       <= '0;
      poll_fail_q <= 1'b0;
    end else begin
      if (cmd_hs) begin
        is_poll_q <= bus.cmd_op == OP_POLL;
        mask_q    <= bus.cmd_mask;
        cnt_q     <= '0;
      end else if (r_hs && retry) cnt_q <= cnt_q + 16'd1;
      if (b_hs) poll_fail_q <= 1'b0;
      if (r_hs) poll_fail_q <= fail;
    end
  end
`else
  assign retry = 1'b0;
  assign fail  = 1'b0;
  assign bus.rsp_poll_fail = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.cmd_valid) state_d = is_wr ? S_WR_REQ : S_RD_REQ;
      S_WR_REQ:  if ((!awvalid_q || bus.m_axi_awready) && (!wvalid_q || bus.m_axi_wready)) state_d = S_WR_RESP;
      S_WR_RESP: if (bus.m_axi_bvalid) state_d = S_RSP;
      S_RD_REQ:  if (bus.m_axi_arready) state_d = S_RD_RESP;
      S_RD_RESP: if (bus.m_axi_rvalid) state_d = retry ? S_RD_REQ : S_RSP;
      S_RSP:     if (bus.rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_hs) begin
        addr_q <= bus.cmd_addr;
        data_q <= bus.cmd_data;
      end
      // AW and W retire independently; the FSM leaves WR_REQ once both have.
      awvalid_q <= (cmd_hs && is_wr) || (awvalid_q && !bus.m_axi_awready);
      wvalid_q  <= (cmd_hs && is_wr) || (wvalid_q && !bus.m_axi_wready);
      arvalid_q <= (cmd_hs && !is_wr) || (r_hs && retry) || (arvalid_q && !bus.m_axi_arready);
      if (b_hs) begin
        rsp_data_q <= '0;
        rsp_resp_q <= bus.m_axi_bresp;
      end
      if (r_hs) begin
        rsp_data_q <= bus.m_axi_rdata;
        rsp_resp_q <= bus.m_axi_rresp;
      end
    end
  end
  assign bus.cmd_ready     = state_q == S_IDLE;
  assign bus.busy          = state_q != S_IDLE;
  assign bus.rsp_valid     = state_q == S_RSP;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_resp      = rsp_resp_q;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_awaddr  = {addr_q[11:2], 2'b00};
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_wdata   = data_q;
  assign bus.m_axi_wstrb   = 4'b1111;
  assign bus.m_axi_bready  = state_q == S_WR_RESP;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_araddr  = {addr_q[11:2], 2'b00};
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_rready  = state_q == S_RD_RESP;
endmodule

// File: tb/tb_jesd204_tpl_regmap_initiator.sv
// tb_jesd204_tpl_regmap_initiator: directed self-checking bench with a configurable-latency AXI4-Lite responder.
// Poll checks follow JESD204_TPL_REGMAP_INITIATOR_POLL_EN; POLL_LIMIT is set to 3 so exhaustion stays short.
module tb_jesd204_tpl_regmap_initiator;
  import jesd204_tpl_regmap_initiator_pkg::*;
  localparam int PL = 3;
  logic up_clk = 1'b0, up_rstn = 1'b0;
  int checks = 0, errors = 0;
  always #5 up_clk = ~up_clk;
  jesd204_tpl_regmap_initiator_if bus ();
  jesd204_tpl_regmap_initiator #(.POLL_LIMIT(PL)) dut (.up_clk(up_clk), .up_rstn(up_rstn), .bus(bus));
  // Responder configuration, written only by the stimulus tasks.
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_wait = 0;
  logic [1:0]  b_resp = RESP_OKAY;
  logic [31:0] rd_data [64];
  logic [1:0]  rd_resp [64];
  // Responder state: B one cycle after AW+W, R two cycles plus r_wait after AR.
  int          aw_wait, w_wait, ar_wait, r_cnt;
  logic        aw_seen, w_seen, bv, r_pend;
  logic [5:0]  rd_idx;
  assign bus.m_axi_awready = bus.m_axi_awvalid && aw_wait == aw_lat;
  assign bus.m_axi_wready  = bus.m_axi_wvalid && w_wait == w_lat;
  assign bus.m_axi_arready = bus.m_axi_arvalid && ar_wait == ar_lat;
  assign bus.m_axi_bvalid  = bv;
  assign bus.m_axi_bresp   = b_resp;
  assign bus.m_axi_rvalid  = r_pend && r_cnt == 0;
  assign bus.m_axi_rdata   = rd_data[rd_idx];
  assign bus.m_axi_rresp   = rd_resp[rd_idx];
  always @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; bv <= 1'b0; r_pend <= 1'b0; rd_idx <= '0;
    end else begin
      aw_wait <= (bus.m_axi_awvalid && !bus.m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.m_axi_wvalid && !bus.m_axi_wready) ? w_wait + 1 : 0;
      ar_wait <= (bus.m_axi_arvalid && !bus.m_axi_arready) ? ar_wait + 1 : 0;
      if (bv && bus.m_axi_bready) bv <= 1'b0;
      if ((aw_seen || (bus.m_axi_awvalid && bus.m_axi_awready)) && (w_seen || (bus.m_axi_wvalid && bus.m_axi_wready))) begin
        bv <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        aw_seen <= aw_seen || (bus.m_axi_awvalid && bus.m_axi_awready);
        w_seen  <= w_seen || (bus.m_axi_wvalid && bus.m_axi_wready);
      end
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        r_pend <= 1'b1; r_cnt <= r_wait + 1;
      end else if (r_pend && r_cnt != 0) r_cnt <= r_cnt - 1;
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        r_pend <= 1'b0; rd_idx <= rd_idx + 6'd1;
      end
    end
  end
  // Bus monitor: handshake counts, cycle stamps and captured payloads.
  int          cyc = 0, aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, aw_hi = 0, w_hi = 0, aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
  logic [11:0] aw_addr = '0, ar_addr = '0;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  always @(posedge up_clk) begin
    cyc   <= cyc + 1;
    aw_hi <= aw_hi + int'(bus.m_axi_awvalid);
    w_hi  <= w_hi + int'(bus.m_axi_wvalid);
    if (bus.m_axi_awvalid && bus.m_axi_awready) begin aw_n <= aw_n + 1; aw_cyc <= cyc; aw_addr <= bus.m_axi_awaddr; end
    if (bus.m_axi_wvalid && bus.m_axi_wready) begin w_n <= w_n + 1; w_cyc <= cyc; w_data <= bus.m_axi_wdata; w_strb <= bus.m_axi_wstrb; end
    if (bus.m_axi_bvalid && bus.m_axi_bready) b_n <= b_n + 1;
    if (bus.m_axi_arvalid && bus.m_axi_arready) begin ar_n <= ar_n + 1; ar_cyc <= cyc; ar_addr <= bus.m_axi_araddr; end
  end
  task automatic set_rd(input int k, input logic [31:0] d, input logic [1:0] r);
    rd_data[rd_idx + 6'(k)] = d;
    rd_resp[rd_idx + 6'(k)] = r;
  endtask
  // Issues one command; n is the acceptance cycle, rc the first rsp_valid cycle; rsp_ready is held low for hold cycles.
  task automatic run_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data, input logic [31:0] mask,
                         input int hold, output logic [31:0] rd, output logic [1:0] resp, output logic pf,
                         output int n, output int rc);
    @(negedge up_clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data; bus.cmd_mask = mask;
    n = cyc;
    @(posedge up_clk);
    #1 bus.cmd_valid = 1'b0;
    rc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge up_clk);
      if (bus.rsp_valid) begin rc = cyc; break; end
    end
    if (rc < 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 200 cycles", bus.rsp_valid);
    end
    rd = bus.rsp_data; resp = bus.rsp_resp; pf = bus.rsp_poll_fail;
    for (int i = 0; i < hold; i++) begin
      @(negedge up_clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== rd || bus.rsp_resp !== resp) begin
        errors++;
        $display("FAIL rsp_hold: valid=%b data=%h resp=%b required 1/%h/%b", bus.rsp_valid, bus.rsp_data, bus.rsp_resp, rd, resp);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge up_clk);
    #1 bus.rsp_ready = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready, bus.m_axi_rready} !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_ctrl: got %b required 10000000", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready, bus.m_axi_rready});
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_resp, bus.rsp_poll_fail, bus.m_axi_awaddr, bus.m_axi_araddr, bus.m_axi_wdata} !== '0) begin
      errors++; $display("FAIL reset_data: rsp_data=%h resp=%b awaddr=%h araddr=%h wdata=%h required 0", bus.rsp_data, bus.rsp_resp, bus.m_axi_awaddr, bus.m_axi_araddr, bus.m_axi_wdata);
    end
    checks++;
    if ({bus.m_axi_awprot, bus.m_axi_arprot, bus.m_axi_wstrb} !== 10'b000_000_1111) begin
      errors++; $display("FAIL reset_const: prot/strb=%b required 0000001111", {bus.m_axi_awprot, bus.m_axi_arprot, bus.m_axi_wstrb});
    end
    @(negedge up_clk) up_rstn = 1'b1;
  endtask
  task automatic test_write;
    logic [31:0] rd; logic [1:0] resp; logic pf; int n, rc, b0;
    b0 = b_n;
    run_cmd(OP_WRITE, 12'h040, 32'h0000_0002, '0, 0, rd, resp, pf, n, rc);
    checks++; if (aw_cyc !== n + 1 || w_cyc !== n + 1) begin errors++; $display("FAIL wr_aw_w_cycle: aw=%0d w=%0d required %0d", aw_cyc, w_cyc, n + 1); end
    checks++; if (aw_addr !== 12'h040 || w_data !== 32'h0000_0002 || w_strb !== 4'b1111) begin errors++; $display("FAIL wr_payload: addr=%h data=%h strb=%b required 040/00000002/1111", aw_addr, w_data, w_strb); end
    checks++; if (rc !== n + 3) begin errors++; $display("FAIL wr_rsp_cycle: got %0d required %0d", rc, n + 3); end
    checks++; if (rd !== 32'h0 || resp !== RESP_OKAY || pf !== 1'b0) begin errors++; $display("FAIL wr_rsp: data=%h resp=%b pf=%b required 0/00/0", rd, resp, pf); end
    checks++; if (b_n - b0 !== 1) begin errors++; $display("FAIL wr_b_count: got %0d required 1", b_n - b0); end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL wr_idle: cmd_ready=%b busy=%b required 1/0", bus.cmd_ready, bus.busy); end
    b_resp = RESP_SLVERR;
    run_cmd(OP_WRITE, 12'h044, 32'hDEAD_BEEF, '0, 0, rd, resp, pf, n, rc);
    b_resp = RESP_OKAY;
    checks++; if (resp !== RESP_SLVERR || rd !== 32'h0) begin errors++; $display("FAIL wr_slverr: resp=%b data=%h required 10/0", resp, rd); end
  endtask
  task automatic test_write_skew(input int al, input int wl);
    logic [31:0] rd; logic [1:0] resp; logic pf; int n, rc, b0, ah0, wh0;
    aw_lat = al; w_lat = wl; b0 = b_n; ah0 = aw_hi; wh0 = w_hi;
    run_cmd(OP_WRITE, 12'h100, 32'h1234_5678, '0, 0, rd, resp, pf, n, rc);
    aw_lat = 0; w_lat = 0;
    checks++; if (aw_hi - ah0 !== al + 1 || w_hi - wh0 !== wl + 1) begin errors++; $display("FAIL skew_valid_len: aw=%0d w=%0d required %0d/%0d", aw_hi - ah0, w_hi - wh0, al + 1, wl + 1); end
    checks++; if (b_n - b0 !== 1) begin errors++; $display("FAIL skew_b_count: got %0d required 1", b_n - b0); end
    checks++; if (rc !== n + 3 + (al > wl ? al : wl)) begin errors++; $display("FAIL skew_rsp_cycle: got %0d required %0d", rc, n + 3 + (al > wl ? al : wl)); end
  endtask
  task automatic test_read;
    logic [31:0] rd; logic [1:0] resp; logic pf; int n, rc, a0;
    set_rd(0, 32'hCAFE_0001, RESP_OKAY);
    a0 = ar_n;
    run_cmd(OP_READ, 12'h010, '0, '0, 0, rd, resp, pf, n, rc);
    checks++; if (ar_cyc !== n + 1 || rc !== n + 4) begin errors++; $display("FAIL rd_timing: ar=%0d rsp=%0d required %0d/%0d", ar_cyc, rc, n + 1, n + 4); end
    checks++; if (rd !== 32'hCAFE_0001 || resp !== RESP_OKAY || ar_n - a0 !== 1) begin errors++; $display("FAIL rd_zero_wait: data=%h resp=%b ar=%0d required cafe0001/00/1", rd, resp, ar_n - a0); end
    set_rd(0, 32'h0009_0262, RESP_OKAY);
    r_wait = 3; a0 = ar_n;
    run_cmd(OP_READ, 12'h000, '0, '0, 2, rd, resp, pf, n, rc);
    r_wait = 0;
    checks++; if (rd !== 32'h0009_0262 || resp !== RESP_OKAY) begin errors++; $display("FAIL rd_wait_data: data=%h resp=%b required 00090262/00", rd, resp); end
    checks++; if (ar_n - a0 !== 1 || rc !== n + 7) begin errors++; $display("FAIL rd_wait_beats: ar=%0d rsp=%0d required 1/%0d", ar_n - a0, rc, n + 7); end
    set_rd(0, 32'h5A5A_A5A5, RESP_OKAY);
    run_cmd(2'b11, 12'h043, '0, '0, 0, rd, resp, pf, n, rc);
    checks++; if (ar_addr !== 12'h040 || rd !== 32'h5A5A_A5A5) begin errors++; $display("FAIL rd_reserved_align: araddr=%h data=%h required 040/5a5aa5a5", ar_addr, rd); end
    set_rd(0, 32'h0, RESP_SLVERR);
    run_cmd(OP_READ, 12'h0FC, '0, '0, 0, rd, resp, pf, n, rc);
    checks++; if (resp !== RESP_SLVERR) begin errors++; $display("FAIL rd_slverr: resp=%b required 10", resp); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] rd; logic [1:0] resp; logic pf; int n1, n2, rc;
    run_cmd(OP_WRITE, 12'h008, 32'h1, '0, 0, rd, resp, pf, n1, rc);
    run_cmd(OP_WRITE, 12'h00C, 32'h2, '0, 0, rd, resp, pf, n2, rc);
    checks++; if (n2 - n1 !== 4) begin errors++; $display("FAIL b2b_write: spacing %0d required 4", n2 - n1); end
    set_rd(0, 32'h11, RESP_OKAY); set_rd(1, 32'h22, RESP_OKAY);
    run_cmd(OP_READ, 12'h008, '0, '0, 0, rd, resp, pf, n1, rc);
    run_cmd(OP_READ, 12'h00C, '0, '0, 0, rd, resp, pf, n2, rc);
    checks++; if (n2 - n1 !== 5 || rd !== 32'h22) begin errors++; $display("FAIL b2b_read: spacing %0d data=%h required 5/00000022", n2 - n1, rd); end
  endtask
  task automatic test_poll;
    logic [31:0] rd; logic [1:0] resp; logic pf; int n, rc, a0;
`ifdef JESD204_TPL_REGMAP_INITIATOR_POLL_EN
    set_rd(0, 32'h0, RESP_OKAY); set_rd(1, 32'hFFFF_FFFE, RESP_OKAY); set_rd(2, 32'hABCD_0001, RESP_OKAY);
    a0 = ar_n;
    run_cmd(OP_POLL, 12'h068, 32'h1, 32'h1, 0, rd, resp, pf, n, rc);
    checks++; if (ar_n - a0 !== 3 || pf !== 1'b0 || rd !== 32'hABCD_0001) begin errors++; $display("FAIL poll_match: ar=%0d pf=%b data=%h required 3/0/abcd0001", ar_n - a0, pf, rd); end
    checks++; if (rc !== n + 10 || ar_addr !== 12'h068) begin errors++; $display("FAIL poll_timing: rsp=%0d araddr=%h required %0d/068", rc, ar_addr, n + 10); end
    for (int k = 0; k < 4; k++) set_rd(k, 32'h0, RESP_OKAY);
    a0 = ar_n;
    run_cmd(OP_POLL, 12'h068, 32'h1, 32'h1, 0, rd, resp, pf, n, rc);
    checks++; if (ar_n - a0 !== PL || pf !== 1'b1 || resp !== RESP_OKAY) begin errors++; $display("FAIL poll_exhaust: ar=%0d pf=%b resp=%b required %0d/1/00", ar_n - a0, pf, resp, PL); end
`else
    set_rd(0, 32'h0, RESP_OKAY); set_rd(1, 32'h1, RESP_OKAY);
    a0 = ar_n;
    run_cmd(OP_POLL, 12'h068, 32'h1, 32'h1, 0, rd, resp, pf, n, rc);
    checks++; if (ar_n - a0 !== 1 || pf !== 1'b0 || rd !== 32'h0 || rc !== n + 4) begin errors++; $display("FAIL poll_as_read: ar=%0d pf=%b data=%h rsp=%0d required 1/0/0/%0d", ar_n - a0, pf, rd, rc, n + 4); end
`endif
    set_rd(0, 32'h0, RESP_SLVERR); set_rd(1, 32'h1, RESP_OKAY);
    a0 = ar_n;
    run_cmd(OP_POLL, 12'h068, 32'h1, 32'h1, 0, rd, resp, pf, n, rc);
    checks++; if (ar_n - a0 !== 1 || resp !== RESP_SLVERR || pf !== 1'b0) begin errors++; $display("FAIL poll_slverr: ar=%0d resp=%b pf=%b required 1/10/0", ar_n - a0, resp, pf); end
  endtask
  task automatic test_reset_mid;
    int a0;
    ar_lat = 10; a0 = ar_n;
    @(negedge up_clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; bus.cmd_addr = 12'h020;
    @(posedge up_clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge up_clk);
    checks++; if (bus.m_axi_arvalid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_arvalid: arvalid=%b busy=%b required 1/1", bus.m_axi_arvalid, bus.busy); end
    up_rstn = 1'b0;
    #1;
    checks++; if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.rsp_valid, bus.m_axi_rready, bus.busy} !== 6'b0) begin errors++; $display("FAIL mid_reset_valids: %b required 000000", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.rsp_valid, bus.m_axi_rready, bus.busy}); end
    @(negedge up_clk) up_rstn = 1'b1;
    ar_lat = 0;
    @(negedge up_clk);
    checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || ar_n - a0 !== 0) begin errors++; $display("FAIL mid_reset_idle: cmd_ready=%b busy=%b ar=%0d required 1/0/0", bus.cmd_ready, bus.busy, ar_n - a0); end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) begin rd_data[i] = '0; rd_resp[i] = RESP_OKAY; end
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0; bus.cmd_mask = '0; bus.rsp_ready = 1'b0;
    test_reset;
    test_write;
    test_write_skew(2, 0);
    test_write_skew(0, 2);
    test_read;
    test_back_to_back;
    test_poll;
    test_reset_mid;
    test_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
